// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: branch-condition codes, next-PC
// source selectors and the branch-condition evaluator.
package risc_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,   // never taken
        BR_ALWAYS = 3'd1,   // always taken
        BR_EQ     = 3'd2,   // taken if zero
        BR_NE     = 3'd3,   // taken if not zero
        BR_CS     = 3'd4,   // taken if carry
        BR_CC     = 3'd5,   // taken if no carry
        BR_PL     = 3'd6,   // taken if sign clear
        BR_MI     = 3'd7    // taken if sign set
    } brtype_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,  // sequential or conditional branch
        SEL_JLABEL = 2'd1,  // absolute jump label
        SEL_JREG   = 2'd2,  // register jump
        SEL_RET    = 2'd3   // return from the return-address stack
    } sel_e;

    // Evaluate a branch condition against the ALU flags.
    function automatic logic br_taken(input logic [2:0] br,
                                      input logic       zero_f,
                                      input logic       carry_f,
                                      input logic       sign_f);
        logic taken;
        case (brtype_e'(br))
            BR_NONE:   taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = zero_f;
            BR_NE:     taken = ~zero_f;
            BR_CS:     taken = carry_f;
            BR_CC:     taken = ~carry_f;
            BR_PL:     taken = ~sign_f;
            BR_MI:     taken = sign_f;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry and keeps occupancy saturated; a pop when empty is refused.
// overflow/underflow flag those events combinationally for the caller.
module ras_stack
    import risc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;        // index of the next free slot
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] ptr_m1_s;
    logic             full_s;

    assign ptr_m1_s  = ptr_r - PTR_W'(1);
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign top       = mem_r[ptr_m1_s];
    assign occupancy = count_r;
    assign overflow  = push & full_s;
    assign underflow = pop & empty;

    // Stack storage, write pointer and occupancy; push wins over pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= PTR_W'(0);
            count_r <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PTR_W'(1);
            if (full_s) begin
                count_r <= count_r;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_r   <= ptr_m1_s;
            count_r <= count_r - CNT_W'(1);
        end else begin
            ptr_r   <= ptr_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/branch_control_ras.sv
// Program-counter and branch-control unit. Evaluates conditional branches,
// absolute and register jumps, and call/return through a return-address
// stack, and raises a one-cycle redirect after any non-sequential update.
module branch_control_ras
    import risc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              OFF_W     = 16,
    parameter int              LABEL_W   = 26,
    parameter int              RAS_DEPTH = 4,
    parameter int              STEP      = 1,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       stall,
    input  logic                       zero_flag,
    input  logic                       carry_flag,
    input  logic                       msb,
    input  logic [2:0]                 brtype,
    input  logic [1:0]                 counter_selector,
    input  logic                       link,
    input  logic [OFF_W-1:0]           branch_label,
    input  logic [LABEL_W-1:0]         jmp_label,
    input  logic [XLEN-1:0]            jmp_ra,
    output logic [XLEN-1:0]            pc,
    output logic                       redirect,
    output logic [$clog2(RAS_DEPTH):0] ras_depth,
    output logic                       ras_err
);

    localparam logic [XLEN-1:0] LABEL_MASK = XLEN'({LABEL_W{1'b1}});

    logic [XLEN-1:0] pc_r;
    logic            redirect_r;
    logic            ras_err_r;

    logic            upd_s;
    logic            taken_s;
    logic [XLEN-1:0] seq_s;
    logic [XLEN-1:0] br_target_s;
    logic [XLEN-1:0] jl_target_s;
    logic [XLEN-1:0] next_pc_s;
    logic            nonseq_s;
    logic            push_req_s;
    logic            pop_req_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_empty_s;
    logic            ras_ovf_s;
    logic            ras_unf_s;

    assign upd_s       = en & ~stall;
    assign taken_s     = br_taken(brtype, zero_flag, carry_flag, msb);
    assign seq_s       = pc_r + XLEN'(STEP);
    assign br_target_s = seq_s + {{(XLEN-OFF_W){branch_label[OFF_W-1]}}, branch_label};
    // Keep the upper bits of the sequential PC and replace the low label bits.
    assign jl_target_s = (seq_s & ~LABEL_MASK) | XLEN'(jmp_label);

    // Next-PC mux, stack requests and redirect decision.
    always_comb begin
        next_pc_s  = seq_s;
        nonseq_s   = 1'b0;
        push_req_s = 1'b0;
        pop_req_s  = 1'b0;
        case (sel_e'(counter_selector))
            SEL_SEQ: begin
                if (taken_s) begin
                    next_pc_s = br_target_s;
                    nonseq_s  = 1'b1;
                end else begin
                    next_pc_s = seq_s;
                    nonseq_s  = 1'b0;
                end
            end
            SEL_JLABEL: begin
                next_pc_s  = jl_target_s;
                nonseq_s   = 1'b1;
                push_req_s = link;
            end
            SEL_JREG: begin
                next_pc_s  = jmp_ra;
                nonseq_s   = 1'b1;
                push_req_s = link;
            end
            SEL_RET: begin
                pop_req_s = 1'b1;
                if (!ras_empty_s) begin
                    next_pc_s = ras_top_s;
                    nonseq_s  = 1'b1;
                end else begin
                    next_pc_s = seq_s;
                    nonseq_s  = 1'b0;
                end
            end
            default: begin
                next_pc_s = seq_s;
                nonseq_s  = 1'b0;
            end
        endcase
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req_s & upd_s),
        .pop       (pop_req_s & upd_s),
        .push_data (seq_s),
        .top       (ras_top_s),
        .occupancy (ras_depth),
        .empty     (ras_empty_s),
        .overflow  (ras_ovf_s),
        .underflow (ras_unf_s)
    );

    // PC register, one-cycle redirect pulse and sticky stack-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            redirect_r <= 1'b0;
            ras_err_r  <= 1'b0;
        end else if (upd_s) begin
            pc_r       <= next_pc_s;
            redirect_r <= nonseq_s;
            ras_err_r  <= ras_err_r | ras_ovf_s | ras_unf_s;
        end else begin
            pc_r       <= pc_r;
            redirect_r <= 1'b0;
            ras_err_r  <= ras_err_r;
        end
    end

    assign pc       = pc_r;
    assign redirect = redirect_r;
    assign ras_err  = ras_err_r;

endmodule

// File: tb/tb_branch_control_ras.sv
// Directed self-checking bench for branch_control_ras. Expected results are
// queued when a step is driven and compared after the following clock edge.
module tb_branch_control_ras;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, stall, zero_flag, carry_flag, msb, link;
    logic [2:0]  brtype;
    logic [1:0]  counter_selector;
    logic [15:0] branch_label;
    logic [25:0] jmp_label;
    logic [31:0] jmp_ra;
    logic [31:0] pc;
    logic        redirect;
    logic [2:0]  ras_depth;
    logic        ras_err;

    typedef struct packed {
        logic [31:0] pc;
        logic        red;
        logic [2:0]  depth;
        logic        err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic [31:0] exp_pc;
    logic [7:0]  taken_tab;

    branch_control_ras dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .msb(msb),
        .brtype(brtype), .counter_selector(counter_selector), .link(link),
        .branch_label(branch_label), .jmp_label(jmp_label), .jmp_ra(jmp_ra),
        .pc(pc), .redirect(redirect), .ras_depth(ras_depth), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // Queue the expectation, clock once, then pop and compare every output.
    task automatic tick(input logic [31:0] e_pc, input logic e_red,
                        input logic [2:0] e_d, input logic e_err, input string tag);
        exp_t  e;
        string t;
        e.pc = e_pc; e.red = e_red; e.depth = e_d; e.err = e_err;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (pc === e.pc) else begin
            miscompares++;
            $error("FAIL %s pc: got %h expected %h", t, pc, e.pc);
        end
        vectors++;
        assert (redirect === e.red) else begin
            miscompares++;
            $error("FAIL %s redirect: got %b expected %b", t, redirect, e.red);
        end
        vectors++;
        assert (ras_depth === e.depth) else begin
            miscompares++;
            $error("FAIL %s ras_depth: got %0d expected %0d", t, ras_depth, e.depth);
        end
        vectors++;
        assert (ras_err === e.err) else begin
            miscompares++;
            $error("FAIL %s ras_err: got %b expected %b", t, ras_err, e.err);
        end
    endtask

    task automatic set_in(input logic [1:0] sel, input logic [2:0] br,
                          input logic lk, input logic [15:0] bl);
        counter_selector = sel;
        brtype           = br;
        link             = lk;
        branch_label     = bl;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0;
        zero_flag = 1'b0; carry_flag = 1'b0; msb = 1'b0;
        set_in(SEL_SEQ, BR_NONE, 1'b0, 16'd0);
        jmp_label = 26'd0; jmp_ra = 32'd0;

        // Reset state and sequential counting.
        tick(32'd0, 1'b0, 3'd0, 1'b0, "reset");
        rst = 1'b0; en = 1'b1;
        tick(32'd1, 1'b0, 3'd0, 1'b0, "seq1");
        tick(32'd2, 1'b0, 3'd0, 1'b0, "seq2");
        tick(32'd3, 1'b0, 3'd0, 1'b0, "seq3");

        // Taken branch, then redirect drops after one cycle.
        rst = 1'b1; tick(32'd0, 1'b0, 3'd0, 1'b0, "rst_b");
        rst = 1'b0;
        set_in(SEL_SEQ, BR_ALWAYS, 1'b0, 16'd71);
        tick(32'd72, 1'b1, 3'd0, 1'b0, "br_always");
        set_in(SEL_SEQ, BR_NONE, 1'b0, 16'd71);
        tick(32'd73, 1'b0, 3'd0, 1'b0, "br_after");
        rst = 1'b1; tick(32'd0, 1'b0, 3'd0, 1'b0, "rst_c");
        rst = 1'b0;
        set_in(SEL_SEQ, BR_EQ, 1'b0, 16'd71);
        tick(32'd1, 1'b0, 3'd0, 1'b0, "br_eq_nt");

        // Every condition code under two opposite flag settings.
        exp_pc = 32'd1;
        zero_flag = 1'b1; carry_flag = 1'b0; msb = 1'b1;
        taken_tab = 8'b1010_0110;
        for (int b = 0; b < 8; b++) begin
            set_in(SEL_SEQ, 3'(b), 1'b0, 16'd10);
            exp_pc = exp_pc + 32'd1 + (taken_tab[b] ? 32'd10 : 32'd0);
            tick(exp_pc, taken_tab[b], 3'd0, 1'b0, $sformatf("brA%0d", b));
        end
        zero_flag = 1'b0; carry_flag = 1'b1; msb = 1'b0;
        taken_tab = 8'b0101_1010;
        for (int b = 0; b < 8; b++) begin
            set_in(SEL_SEQ, 3'(b), 1'b0, 16'd10);
            exp_pc = exp_pc + 32'd1 + (taken_tab[b] ? 32'd10 : 32'd0);
            tick(exp_pc, taken_tab[b], 3'd0, 1'b0, $sformatf("brB%0d", b));
        end
        zero_flag = 1'b0; carry_flag = 1'b0; msb = 1'b0;

        // Register call immediately followed by return; label jumps.
        rst = 1'b1; tick(32'd0, 1'b0, 3'd0, 1'b0, "rst_d");
        rst = 1'b0;
        set_in(SEL_JREG, BR_NONE, 1'b1, 16'd0); jmp_ra = 32'd1045;
        tick(32'd1045, 1'b1, 3'd1, 1'b0, "call_jreg");
        set_in(SEL_RET, BR_ALWAYS, 1'b0, 16'd0);
        tick(32'd1, 1'b1, 3'd0, 1'b0, "ret");
        set_in(SEL_JREG, BR_NONE, 1'b0, 16'd0); jmp_ra = 32'hA400_0010;
        tick(32'hA400_0010, 1'b1, 3'd0, 1'b0, "jreg_nolink");
        set_in(SEL_JLABEL, BR_NONE, 1'b0, 16'd0); jmp_label = 26'h000_0123;
        tick(32'hA400_0123, 1'b1, 3'd0, 1'b0, "jlabel");
        set_in(SEL_SEQ, BR_NONE, 1'b1, 16'd0);
        tick(32'hA400_0124, 1'b0, 3'd0, 1'b0, "link_sel0");

        // Five calls into a four-entry stack, then five returns.
        rst = 1'b1; tick(32'd0, 1'b0, 3'd0, 1'b0, "rst_e");
        rst = 1'b0;
        set_in(SEL_JREG, BR_NONE, 1'b1, 16'd0);
        jmp_ra = 32'd100; tick(32'd100, 1'b1, 3'd1, 1'b0, "call1");
        jmp_ra = 32'd200; tick(32'd200, 1'b1, 3'd2, 1'b0, "call2");
        jmp_ra = 32'd300; tick(32'd300, 1'b1, 3'd3, 1'b0, "call3");
        jmp_ra = 32'd400; tick(32'd400, 1'b1, 3'd4, 1'b0, "call4");
        jmp_ra = 32'd500; tick(32'd500, 1'b1, 3'd4, 1'b1, "call5_ovf");
        set_in(SEL_RET, BR_NONE, 1'b1, 16'd0);
        tick(32'd401, 1'b1, 3'd3, 1'b1, "ret5");
        tick(32'd301, 1'b1, 3'd2, 1'b1, "ret4");
        tick(32'd201, 1'b1, 3'd1, 1'b1, "ret3");
        tick(32'd101, 1'b1, 3'd0, 1'b1, "ret2");
        tick(32'd102, 1'b0, 3'd0, 1'b1, "ret_unf");

        // Wrap-around branch, zero-offset branch, stall and disable.
        rst = 1'b1; tick(32'd0, 1'b0, 3'd0, 1'b0, "rst_f");
        rst = 1'b0;
        set_in(SEL_JREG, BR_NONE, 1'b0, 16'd0); jmp_ra = 32'hFFFF_FFFF;
        tick(32'hFFFF_FFFF, 1'b1, 3'd0, 1'b0, "jreg_max");
        set_in(SEL_SEQ, BR_ALWAYS, 1'b0, 16'hFFFF);
        tick(32'hFFFF_FFFF, 1'b1, 3'd0, 1'b0, "br_wrap");
        stall = 1'b1;
        set_in(SEL_SEQ, BR_ALWAYS, 1'b0, 16'd71);
        tick(32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, "stall_br");
        set_in(SEL_JREG, BR_NONE, 1'b1, 16'd0);
        tick(32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, "stall_call");
        stall = 1'b0; en = 1'b0;
        tick(32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, "en_low");
        en = 1'b1;
        set_in(SEL_SEQ, BR_ALWAYS, 1'b0, 16'd0);
        tick(32'd0, 1'b1, 3'd0, 1'b0, "br_off0");

        // Reset in the middle of a call sequence discards the stack.
        set_in(SEL_RET, BR_NONE, 1'b0, 16'd0);
        tick(32'd1, 1'b0, 3'd0, 1'b1, "unf_first");
        set_in(SEL_JREG, BR_NONE, 1'b1, 16'd0); jmp_ra = 32'd50;
        tick(32'd50, 1'b1, 3'd1, 1'b1, "mid_call1");
        jmp_ra = 32'd60;
        tick(32'd60, 1'b1, 3'd2, 1'b1, "mid_call2");
        rst = 1'b1;
        tick(32'd0, 1'b0, 3'd0, 1'b0, "mid_rst");
        rst = 1'b0;
        set_in(SEL_RET, BR_NONE, 1'b0, 16'd0);
        tick(32'd1, 1'b0, 3'd0, 1'b1, "ret_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
